// File: rtl/sw_sram_arbiter_if.sv
// sw_sram_arbiter_if: requester, SRAM and status signals of the sequence SRAM read-port arbiter
interface sw_sram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
);
    logic              req_t_i;
    logic [ADDR_W-1:0] addr_t_i;
    logic              gnt_t_o;
    logic [WORD_W-1:0] rdata_t_o;
    logic              rvalid_t_o;
    logic              req_q_i;
    logic [ADDR_W-1:0] addr_q_i;
    logic              gnt_q_o;
    logic [WORD_W-1:0] rdata_q_o;
    logic              rvalid_q_o;
    logic              sel_T_o;
    logic [ADDR_W-1:0] addr_o;
    logic              rd_en_o;
    logic [WORD_W-1:0] data_i;
    logic              busy_o;

    modport slave (
        input  req_t_i, addr_t_i, req_q_i, addr_q_i, data_i,
        output gnt_t_o, rdata_t_o, rvalid_t_o, gnt_q_o, rdata_q_o, rvalid_q_o,
        output sel_T_o, addr_o, rd_en_o, busy_o
    );

    modport master (
        output req_t_i, addr_t_i, req_q_i, addr_q_i, data_i,
        input  gnt_t_o, rdata_t_o, rvalid_t_o, gnt_q_o, rdata_q_o, rvalid_q_o,
        input  sel_T_o, addr_o, rd_en_o, busy_o
    );
endinterface

// File: rtl/sw_sram_arbiter.sv
// sw_sram_arbiter: shares the sequence SRAM read port between the target and query fetchers
module sw_sram_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int WORD_W    = 32,
    parameter int MAX_BURST = 8
) (
    input logic              clk,
    input logic              rst_n,
    sw_sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN_T, OWN_Q, SWITCH} state_t;
    localparam logic [7:0] CAP = 8'(MAX_BURST - 1);

    state_t            state, state_nxt;
    logic              rr, next_owner, next_owner_nxt;
    logic [7:0]        cnt;
    logic              req_x, req_y, gnt_t, gnt_q, acc;
    logic [ADDR_W-1:0] addr_sel, addr_r;
    logic              sel_t, rd_en, v2, t2, rvalid_t, rvalid_q;
    logic [WORD_W-1:0] rdata_t, rdata_q;

    always_comb begin
        state_nxt      = state;
        next_owner_nxt = next_owner;
        req_x          = (state == OWN_T) ? bus.req_t_i : bus.req_q_i;
        req_y          = (state == OWN_T) ? bus.req_q_i : bus.req_t_i;
        gnt_t          = (state == OWN_T) && bus.req_t_i;
        gnt_q          = (state == OWN_Q) && bus.req_q_i;
        acc            = gnt_t || gnt_q;
        addr_sel       = gnt_t ? bus.addr_t_i : bus.addr_q_i;
        case (state)
            IDLE: if (bus.req_t_i || bus.req_q_i)
                state_nxt = (bus.req_t_i && (rr || !bus.req_q_i)) ? OWN_T : OWN_Q;
            OWN_T, OWN_Q:
                // a held request at the cap only yields when the other side is waiting
                if (req_y && (!req_x || cnt == CAP)) begin
                    state_nxt      = SWITCH;
                    next_owner_nxt = (state == OWN_Q);
                end else if (!req_x) state_nxt = IDLE;
            default: state_nxt = next_owner ? OWN_T : OWN_Q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr         <= 1'b1;
            next_owner <= 1'b0;
            cnt        <= 8'd0;
            sel_t      <= 1'b0;
            addr_r     <= '0;
            rd_en      <= 1'b0;
            v2         <= 1'b0;
            t2         <= 1'b0;
            rvalid_t   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_t    <= '0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            next_owner <= next_owner_nxt;
            if ((state == OWN_T || state == OWN_Q) && state_nxt != state) rr <= (state == OWN_Q);
            cnt        <= (state_nxt != state) ? 8'd0 : (acc && cnt != CAP) ? cnt + 8'd1 : cnt;
            rd_en      <= acc;
            if (acc) begin
                addr_r <= addr_sel;
                sel_t  <= gnt_t;
            end
            v2       <= rd_en;
            t2       <= sel_t;
            rvalid_t <= v2 && t2;
            rvalid_q <= v2 && !t2;
            if (v2 && t2) rdata_t <= bus.data_i;
            if (v2 && !t2) rdata_q <= bus.data_i;
        end
    end

    assign bus.gnt_t_o    = gnt_t;
    assign bus.gnt_q_o    = gnt_q;
    assign bus.sel_T_o    = sel_t;
    assign bus.addr_o     = addr_r;
    assign bus.rd_en_o    = rd_en;
    assign bus.rvalid_t_o = rvalid_t;
    assign bus.rvalid_q_o = rvalid_q;
    assign bus.rdata_t_o  = rdata_t;
    assign bus.rdata_q_o  = rdata_q;
    assign bus.busy_o     = (state != IDLE) || rd_en || v2;
endmodule

// File: tb/tb_sw_sram_arbiter.sv
// tb_sw_sram_arbiter: directed scenarios plus random traffic checked against an ownership/tenure model
module tb_sw_sram_arbiter;
    localparam int AW = 10;
    localparam int WW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    sw_sram_arbiter_if #(.ADDR_W(AW), .WORD_W(WW)) bus();
    sw_sram_arbiter #(.ADDR_W(AW), .WORD_W(WW), .MAX_BURST(MB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [31:0] tdat(input logic [AW-1:0] a);
        return 32'h100 + 32'(a);
    endfunction

    function automatic logic [31:0] qdat(input logic [AW-1:0] a);
        return 32'hA500_0000 ^ (32'(a) * 32'd7);
    endfunction

    // synchronous SRAM pair: word appears the cycle after the address
    always @(posedge clk) bus.data_i <= bus.sel_T_o ? tdat(bus.addr_o) : qdat(bus.addr_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // reference model: who owns the port, how many beats this tenure, pending returns
    typedef struct {
        logic          is_t;
        logic [AW-1:0] a;
        int            due;
    } rd_t;
    rd_t           pend[$];
    rd_t           r;
    int            m_own = -1;
    int            m_rr = 0;
    int            m_bub_to = 0;
    int            m_beats = 0;
    logic          m_bub = 1'b0;
    logic          e_rd = 1'b0, e_sel = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0]   e_rt = '0, e_rq = '0;
    logic          rt, rq, gt, gq, vt, vq, mine, oth, ebusy;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
            m_own = -1; m_rr = 0; m_bub = 1'b0; m_beats = 0;
            e_rd = 1'b0; e_sel = 1'b0; e_addr = '0; e_rt = '0; e_rq = '0;
            chk("rst_ctl", 64'({bus.gnt_t_o, bus.gnt_q_o, bus.rvalid_t_o, bus.rvalid_q_o,
                                bus.rd_en_o, bus.sel_T_o, bus.busy_o, bus.addr_o}), 64'd0);
            chk("rst_rdata", 64'({bus.rdata_t_o, bus.rdata_q_o}), 64'd0);
        end else begin
            rt = bus.req_t_i;
            rq = bus.req_q_i;
            gt = !m_bub && m_own == 0 && rt;
            gq = !m_bub && m_own == 1 && rq;
            vt = 1'b0;
            vq = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                if (r.is_t) begin vt = 1'b1; e_rt = tdat(r.a); end
                else begin vq = 1'b1; e_rq = qdat(r.a); end
            end
            ebusy = m_bub || m_own != -1 || pend.size() > 0;
            chk("gnt", 64'({bus.gnt_t_o, bus.gnt_q_o}), 64'({gt, gq}));
            chk("rvalid", 64'({bus.rvalid_t_o, bus.rvalid_q_o}), 64'({vt, vq}));
            chk("rdata_t", 64'(bus.rdata_t_o), 64'(e_rt));
            chk("rdata_q", 64'(bus.rdata_q_o), 64'(e_rq));
            chk("issue", 64'({bus.rd_en_o, bus.sel_T_o, bus.addr_o}), 64'({e_rd, e_sel, e_addr}));
            chk("busy", 64'(bus.busy_o), 64'(ebusy));
            e_rd = gt || gq;
            if (e_rd) begin
                e_sel  = gt;
                e_addr = gt ? bus.addr_t_i : bus.addr_q_i;
                pend.push_back('{gt, e_addr, cyc + 3});
            end
            if (m_bub) begin
                m_bub = 1'b0; m_own = m_bub_to; m_beats = 0;
            end else if (m_own < 0) begin
                m_own = (rt && rq) ? m_rr : rt ? 0 : rq ? 1 : -1;
                m_beats = 0;
            end else begin
                mine = (m_own == 0) ? rt : rq;
                oth  = (m_own == 0) ? rq : rt;
                if (mine) m_beats++;
                if (!mine || (oth && m_beats >= MB)) begin
                    m_rr = 1 - m_own;
                    if (oth) begin m_bub = 1'b1; m_bub_to = 1 - m_own; end
                    m_own = -1;
                end
            end
        end
    end

    task automatic idle_reqs();
        bus.req_t_i = 1'b0; bus.req_q_i = 1'b0;
        bus.addr_t_i = '0;  bus.addr_q_i = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_reqs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    logic [1:0] eg;

    initial begin
        idle_reqs();
        do_reset();
        // T-only burst of four beats
        for (int k = 0; k < 9; k++) begin
            bus.req_t_i  = (k <= 4);
            bus.addr_t_i = AW'(k > 0 ? k - 1 : 0);
            @(negedge clk);
            chk("p1_gnt_t", 64'(bus.gnt_t_o), 64'(k >= 1 && k <= 4));
            if (k >= 2 && k <= 5)
                chk("p1_addr", 64'({bus.sel_T_o, bus.rd_en_o, bus.addr_o}), 64'({2'b11, AW'(k - 2)}));
            chk("p1_rvalid_t", 64'(bus.rvalid_t_o), 64'(k >= 4 && k <= 7));
            if (k >= 4 && k <= 7) chk("p1_rdata_t", 64'(bus.rdata_t_o), 64'(32'h100 + 32'(k - 4)));
            chk("p1_rvalid_q", 64'(bus.rvalid_q_o), 64'd0);
            next_cycle();
        end
        // simultaneous start, T leaves after two beats
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus.req_t_i  = (k <= 2);
            bus.req_q_i  = (k <= 6);
            bus.addr_t_i = AW'($urandom);
            bus.addr_q_i = AW'($urandom);
            @(negedge clk);
            eg = (k == 1 || k == 2) ? 2'b10 : (k == 5 || k == 6) ? 2'b01 : 2'b00;
            chk("p2_gnt", 64'({bus.gnt_t_o, bus.gnt_q_o}), 64'(eg));
            if (k == 4) chk("p2_switch_busy", 64'(bus.busy_o), 64'd1);
            next_cycle();
        end
        // fairness cap with both requesters always asking
        do_reset();
        for (int k = 0; k < 26; k++) begin
            bus.req_t_i  = (k < 22);
            bus.req_q_i  = (k < 22);
            bus.addr_t_i = AW'($urandom);
            bus.addr_q_i = AW'($urandom);
            @(negedge clk);
            if (k >= 1 && k <= 21) begin
                eg = ((k - 1) % 5 == 4) ? 2'b00 : (((k - 1) / 5) % 2 == 0) ? 2'b10 : 2'b01;
                chk("p3_pattern", 64'({bus.gnt_t_o, bus.gnt_q_o}), 64'(eg));
            end
            next_cycle();
        end
        // Q alone saturates, then T arrives
        do_reset();
        for (int k = 0; k < 26; k++) begin
            bus.req_q_i  = 1'b1;
            bus.req_t_i  = (k >= 21);
            bus.addr_t_i = AW'($urandom);
            bus.addr_q_i = AW'(k);
            @(negedge clk);
            eg = (k >= 1 && k <= 21) ? 2'b01 : (k >= 23) ? 2'b10 : 2'b00;
            chk("p4_gnt", 64'({bus.gnt_t_o, bus.gnt_q_o}), 64'(eg));
            next_cycle();
        end
        // reset right after a read is issued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.req_t_i  = (k <= 1);
            bus.addr_t_i = AW'(5);
            @(negedge clk);
            if (k == 2) chk("p5_rd_en", 64'(bus.rd_en_o), 64'd1);
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        chk("p5_async_ctl", 64'({bus.gnt_t_o, bus.gnt_q_o, bus.rvalid_t_o, bus.rvalid_q_o,
                                 bus.rd_en_o, bus.sel_T_o, bus.busy_o, bus.addr_o}), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("p5_dropped", 64'({bus.rvalid_t_o, bus.rvalid_q_o}), 64'd0);
            next_cycle();
        end
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            bus.req_t_i  = (j <= 1);
            bus.addr_t_i = AW'(9);
            @(negedge clk);
            chk("p5_rvalid_t", 64'(bus.rvalid_t_o), 64'(j == 4));
            if (j == 4) chk("p5_rdata_t", 64'(bus.rdata_t_o), 64'(32'h109));
            next_cycle();
        end
        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) bus.req_t_i = ~bus.req_t_i;
            if ($urandom_range(0, 3) == 0) bus.req_q_i = ~bus.req_q_i;
            bus.addr_t_i = AW'($urandom);
            bus.addr_q_i = AW'($urandom);
            next_cycle();
        end
        rst_n = 1'b1;
        idle_reqs();
        repeat (6) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sw_sram_arbiter.md
# sw_sram_arbiter

Shares the single read port of the sequence SRAM between the target fetcher and the query fetcher of the SmithWaterman core. It drives the `sel_T`/`addr` pair seen by the external memory, captures the returned word, and routes it back to whichever requester issued it. Ownership follows bursts with a fairness cap. A one-cycle bubble is inserted on every change of owner so the T/Q memory select can settle.

## Interface
- `ADDR_W`, default 10: SRAM address width.
- `WORD_W`, default 32: SRAM word width.
- `MAX_BURST`, default 8: maximum consecutive grants to one owner while the other requester is waiting. Legal range is 1..255.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_t_i`, in, 1: target fetcher requests a read.
- `addr_t_i`, in, `ADDR_W`: target read address.
- `gnt_t_o`, out, 1: combinational grant. The beat is accepted in any cycle where `req_t_i` and `gnt_t_o` are both high.
- `rdata_t_o`, out, `WORD_W`: returned target word.
- `rvalid_t_o`, out, 1: one-cycle pulse qualifying `rdata_t_o`.
- `req_q_i`, `addr_q_i`, `gnt_q_o`, `rdata_q_o`, `rvalid_q_o`: same as the target set, for the query fetcher.
- `sel_T_o`, out, 1: memory select, registered. 1 selects the target SRAM, 0 the query SRAM.
- `addr_o`, out, `ADDR_W`: registered SRAM address.
- `rd_en_o`, out, 1: registered; high for one cycle per issued read.
- `data_i`, in, `WORD_W`: SRAM read data. Valid in the cycle after `addr_o`/`sel_T_o` change and sampled on the following rising edge.
- `busy_o`, out, 1: high when the FSM is not in IDLE, or a read is in flight.

## Operation
- States:
  - IDLE
  - OWN_T
  - OWN_Q
  - SWITCH, which also holds a 1-bit `next_owner`
- Round-robin pointer `rr`:
  - Reset value: T.
  - Updated to the opposite of the owner on every exit from OWN_T or OWN_Q.
- IDLE:
  - No grants.
  - Both requests high: go to OWN_{rr}.
  - Exactly one request high: go to that owner's state.
  - No request: stay.
- OWN_x:
  - `gnt_x_o = req_x_i`. The other grant is 0.
  - Each accepted beat:
    - Registers `addr_x_i` into `addr_o`.
    - Sets `sel_T_o = (x==T)` and `rd_en_o = 1`.
    - Increments the 8-bit burst counter `cnt`.
  - `req_x_i` low, `req_y_i` high: go to SWITCH with `next_owner = y`.
  - `req_x_i` low, `req_y_i` low: go to IDLE.
  - Beat accepted with `cnt == MAX_BURST-1` and `req_y_i` high: this beat completes, then go to SWITCH with `next_owner = y`.
  - `req_y_i` low: `cnt` saturates at `MAX_BURST-1`. The owner continues indefinitely. A later `req_y_i` forces a switch after the owner's next beat.
- SWITCH:
  - No grants, `rd_en_o = 0`.
  - Clear `cnt`.
  - Next state: OWN_{next_owner}, unconditionally. If that requester has dropped `req`, OWN handles it on the following cycle.
- Return path:
  - A 2-stage shift register carries `{valid, is_T}` alongside each read.
  - Stage 1 aligns with `rd_en_o`.
  - On the edge ending the data cycle, `data_i` is captured into `rdata_x_o` and the matching `rvalid_x_o` pulses.
  - `rdata_*_o` holds its value between pulses.
  - `rdata_t_o` and `rdata_q_o` are separate registers. Only the addressed one updates.
- `addr_o` and `sel_T_o` hold their last values when no read is issued.

## Timing
- Reset values:
  - State IDLE, `rr` = T, `cnt` = 0.
  - `sel_T_o` = 0, `addr_o` = 0, `rd_en_o` = 0.
  - `rdata_*_o` = 0, `rvalid_*_o` = 0.
  - `gnt_*_o` = 0, `busy_o` = 0.
- Pipeline, with a request rising in cycle 0 from IDLE:
  - Cycle 1: OWN, grant.
  - Cycle 2: `addr_o`/`rd_en_o`.
  - Cycle 3: `data_i` valid.
  - Cycle 4: `rvalid`.
- Grant-to-`rvalid` latency: 3 cycles.
- Throughput: one beat per cycle within a burst. One bubble cycle on each owner change.
- Order: returns arrive in issue order. At most one `rvalid` (T or Q) is asserted per cycle.
- Asynchronous reset mid-operation:
  - In-flight reads are dropped. No `rvalid` fires for them.
  - All outputs return to reset values immediately.
- Requester changing `addr_x_i` while not granted: no effect.
- `MAX_BURST = 1`: strict alternation whenever both requesters are active.

## Test plan
- **T-only burst:** `req_t_i` high 4 cycles, addresses 0..3, T_mem[i] = 0x100+i, starting from IDLE. Required:
  - `gnt_t_o` high on cycles 1..4.
  - `addr_o` 0..3 on cycles 2..5 with `sel_T_o = 1`.
  - `rvalid_t_o` cycles 4..7 with data 0x100..0x103.
  - `rvalid_q_o` never asserts.
- **Simultaneous start:** both requests rise together after reset. Required:
  - T is granted first (`rr` = T).
  - When T drops its request after 2 beats, the next cycle is SWITCH with no grant.
  - Q is granted on the cycle after that.
- **Fairness cap:** `MAX_BURST = 4`, both requests held high for 20 cycles. Required:
  - Grants follow the repeating pattern T×4, bubble, Q×4, bubble, T×4, ...
  - Every `rvalid` is routed to the requester that issued the beat.
- **No-contention saturation:** Q alone requests for 20 beats. Required:
  - 20 consecutive grants with no bubble.
  - `req_t_i` raised at beat 20: Q gets exactly one more grant, then SWITCH, then T.
- **Reset mid-flight:** assert `rst_n = 0` in the cycle after `rd_en_o` pulses. Required:
  - No `rvalid` for that read.
  - All outputs at reset values.
  - A fresh T request after release completes with the normal 3-cycle latency.
